// File: rtl/shazam_pkg.sv
// Constants and types shared by the frame scheduler and the peak finder.
package shazam_pkg;
  localparam int BINS      = 512;
  localparam int MAX_COUNT = 11;
  localparam int MAG_W     = 25;
  localparam int IDX_W     = 9;

  typedef enum logic [2:0] {
    FLUSH = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    EMIT  = 3'd4
  } sched_state_t;

  typedef logic [IDX_W-1:0] peak_idx_t;
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;

  // count events, holding at full scale
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= {W{1'b0}};
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/maxima_frame_scheduler.sv
// Feeds one FFT frame at a time into the peak finder, runs the search and
// hands the captured peak indices downstream, aborting malformed or stalled frames.
module maxima_frame_scheduler
  import shazam_pkg::*;
#(
  parameter int TIMEOUT = 65535,
  parameter int FID_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [MAG_W-1:0]           in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [MAG_W-1:0]           fm_data,
  output logic                       fm_load,
  output logic                       fm_start,
  output logic                       fm_reset,
  input  logic [MAX_COUNT*IDX_W-1:0] fm_indices,
  input  logic                       fm_done,
  output logic [MAX_COUNT*IDX_W-1:0] out_indices,
  output logic [FID_W-1:0]           out_frame_id,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 err_frame_cnt,
  output logic [7:0]                 err_timeout_cnt
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(BINS - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);

  sched_state_t               r_state;
  sched_state_t               w_next;
  logic [IDX_W-1:0]           r_bin_cnt;
  logic [WD_W-1:0]            r_wdog;
  logic [FID_W-1:0]           r_frame_id;
  logic [MAX_COUNT*IDX_W-1:0] r_indices;
  logic                       w_accept;
  logic                       w_bad_frame;
  logic                       w_timeout;

  assign in_ready = (r_state == LOAD);
  assign w_accept = in_valid && in_ready;
  assign fm_load  = w_accept;
  assign fm_data  = in_ready ? in_data : {MAG_W{1'b0}};
  assign fm_start = (r_state == START);
  assign fm_reset = (r_state == FLUSH);
  assign out_valid    = (r_state == EMIT);
  assign out_indices  = r_indices;
  assign out_frame_id = r_frame_id;

  // A frame is malformed when in_last disagrees with reaching the final bin.
  assign w_bad_frame = w_accept && (in_last != (r_bin_cnt == LAST_BIN));
  assign w_timeout   = (r_state == WAIT) && !fm_done && (r_wdog == WD_MAX);

  // next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      FLUSH: w_next = LOAD;
      LOAD: begin
        if (w_bad_frame) w_next = FLUSH;
        else if (w_accept && in_last) w_next = START;
        else w_next = LOAD;
      end
      START: w_next = WAIT;
      WAIT: begin
        if (fm_done) w_next = EMIT;
        else if (w_timeout) w_next = FLUSH;
        else w_next = WAIT;
      end
      EMIT: begin
        if (out_ready) w_next = LOAD;
        else w_next = EMIT;
      end
      default: w_next = FLUSH;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FLUSH;
    else        r_state <= w_next;
  end

  // bin counter, watchdog, frame id and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bin_cnt  <= {IDX_W{1'b0}};
      r_wdog     <= {WD_W{1'b0}};
      r_frame_id <= {FID_W{1'b0}};
      r_indices  <= {(MAX_COUNT*IDX_W){1'b0}};
    end else begin
      case (r_state)
        FLUSH: r_bin_cnt <= {IDX_W{1'b0}};
        LOAD: begin
          if (w_accept) begin
            r_bin_cnt <= (w_bad_frame || in_last) ? {IDX_W{1'b0}} : r_bin_cnt + IDX_W'(1);
          end
        end
        START: r_wdog <= {WD_W{1'b0}};
        WAIT: begin
          if (fm_done) r_indices <= fm_indices;
          else if (!w_timeout) r_wdog <= r_wdog + WD_W'(1);
        end
        EMIT: begin
          if (out_ready) begin
            r_frame_id <= r_frame_id + FID_W'(1);
            r_bin_cnt  <= {IDX_W{1'b0}};
          end
        end
        default: r_bin_cnt <= {IDX_W{1'b0}};
      endcase
    end
  end

  sat_counter #(.W(8)) u_err_frame (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_bad_frame),
    .o_cnt (err_frame_cnt)
  );

  sat_counter #(.W(8)) u_err_timeout (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_timeout),
    .o_cnt (err_timeout_cnt)
  );
endmodule

// File: tb/tb_maxima_frame_scheduler.sv
// Directed-random bench: a behavioural peak finder sits behind the scheduler and
// each frame carries eleven planted peaks whose ranked positions are the expected result.
module tb_maxima_frame_scheduler;
  import shazam_pkg::*;

  localparam int TO    = 100;
  localparam int FID_W = 16;
  localparam int IW    = MAX_COUNT * IDX_W;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [MAG_W-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [MAG_W-1:0] fm_data;
  logic             fm_load, fm_start, fm_reset;
  logic [IW-1:0]    fm_indices = '0;
  logic             fm_done = 1'b0;
  logic [IW-1:0]    out_indices;
  logic [FID_W-1:0] out_frame_id;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [7:0]       err_frame_cnt, err_timeout_cnt;

  int total = 0;
  int bad = 0;

  maxima_frame_scheduler #(.TIMEOUT(TO), .FID_W(FID_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .fm_data(fm_data), .fm_load(fm_load), .fm_start(fm_start),
    .fm_reset(fm_reset), .fm_indices(fm_indices), .fm_done(fm_done),
    .out_indices(out_indices), .out_frame_id(out_frame_id), .out_valid(out_valid),
    .out_ready(out_ready), .err_frame_cnt(err_frame_cnt), .err_timeout_cnt(err_timeout_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural finder: circular load buffer, ranked top-k search after a fixed latency.
  logic [MAG_W-1:0] fbuf [BINS];
  int fptr = 0;
  int fdelay = 0;
  bit stub_en = 1'b1;

  function automatic logic [IW-1:0] top_of();
    logic [IW-1:0] r;
    bit used [BINS];
    int best;
    r = '0;
    for (int i = 0; i < BINS; i++) used[i] = 1'b0;
    for (int k = 0; k < MAX_COUNT; k++) begin
      best = -1;
      for (int i = 0; i < BINS; i++)
        if (!used[i] && (best < 0 || fbuf[i] > fbuf[best])) best = i;
      used[best] = 1'b1;
      r[k*IDX_W +: IDX_W] = IDX_W'(best);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    fm_done <= 1'b0;
    if (fm_reset) fptr <= 0;
    else if (fm_load) begin
      fbuf[fptr] <= fm_data;
      fptr <= (fptr + 1) % BINS;
    end
    if (fm_start && stub_en) fdelay <= 20;
    else if (fdelay > 0) begin
      fdelay <= fdelay - 1;
      if (fdelay == 1) begin
        fm_done <= 1'b1;
        fm_indices <= top_of();
      end
    end
  end

  // Activity counters and strobe-exclusivity monitor.
  int n_load = 0, n_start = 0, n_reset = 0, n_ovalid = 0, n_viol = 0;
  always @(negedge clk) begin
    if (fm_load) n_load++;
    if (fm_start) n_start++;
    if (fm_reset) n_reset++;
    if (out_valid) n_ovalid++;
    if ((fm_load && fm_start) || (fm_reset && (fm_load || fm_start))) n_viol++;
  end

  logic [MAG_W-1:0] frame [BINS];
  logic [IW-1:0]    exp_idx;
  int exp_fid = 0, exp_ef = 0, exp_et = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Plant eleven peaks of strictly decreasing height over a background below them all.
  task automatic gen_frame(input bit nominal);
    int pos [MAX_COUNT];
    bit taken [BINS];
    int p;
    for (int i = 0; i < BINS; i++) begin
      taken[i] = 1'b0;
      frame[i] = nominal ? MAG_W'(i) : MAG_W'($urandom_range(0, 20'hFFFFF));
    end
    for (int k = 0; k < MAX_COUNT; k++) begin
      if (nominal && k == 0) p = 100;
      else if (nominal && k == 1) p = 300;
      else begin
        p = $urandom_range(0, BINS - 1);
        while (taken[p]) p = $urandom_range(0, BINS - 1);
      end
      taken[p] = 1'b1;
      pos[k] = p;
      frame[p] = 25'h1FFFFFF - MAG_W'(k);
      exp_idx[k*IDX_W +: IDX_W] = IDX_W'(p);
    end
  endtask

  task automatic send_beat(input logic [MAG_W-1:0] d, input logic last);
    int guard = 0;
    if ($urandom_range(0, 7) == 0) step();
    in_data = d; in_last = last; in_valid = 1'b1;
    while (!in_ready && guard < 1000) begin step(); guard++; end
    if (guard >= 1000) check("beat_accept_timeout", guard, 0);
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int n, input int last_at);
    for (int i = 0; i < n; i++) send_beat(frame[i % BINS], (i == last_at));
  endtask

  task automatic wait_result(input string tag, input int hold);
    int guard = 0;
    bit steady = 1'b1;
    logic [IW-1:0] snap;
    while (!out_valid && guard < 300) begin step(); guard++; end
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_idx"}, out_indices, exp_idx);
    check({tag, "_fid"}, out_frame_id, FID_W'(exp_fid));
    snap = out_indices;
    for (int c = 0; c < hold; c++) begin
      step();
      if (out_indices !== snap || in_ready !== 1'b0 || out_valid !== 1'b1) steady = 1'b0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, steady, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_fid = (exp_fid + 1) % (1 << FID_W);
    check({tag, "_drop_valid"}, out_valid, 1'b0);
    check({tag, "_reload"}, in_ready, 1'b1);
  endtask

  task automatic good_frame(input string tag, input bit nominal, input int hold);
    gen_frame(nominal);
    send_frame(BINS, BINS - 1);
    check({tag, "_start"}, fm_start, 1'b1);
    wait_result(tag, hold);
  endtask

  initial begin
    int l0, s0, r0, v0;
    // Reset state
    repeat (3) step();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_fm_reset", fm_reset, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_strobes", {fm_load, fm_start}, 2'b00);
    check("rst_errs", {err_frame_cnt, err_timeout_cnt}, 16'h0);
    check("rst_fid_idx", {out_frame_id, out_indices}, '0);
    reset = 1'b1;
    check("flush_cycle", fm_reset, 1'b1);
    step();
    check("load_after_flush", {in_ready, fm_reset}, 2'b10);

    // Nominal frame with backpressure
    l0 = n_load; s0 = n_start;
    good_frame("nominal", 1'b1, 50);
    check("nominal_loads", n_load - l0, BINS);
    check("nominal_starts", n_start - s0, 1);
    good_frame("second", 1'b0, 3);

    // Short frame
    gen_frame(1'b0);
    r0 = n_reset; v0 = n_ovalid;
    send_frame(10, 9);
    exp_ef++;
    check("short_err", err_frame_cnt, exp_ef);
    check("short_flush", {fm_reset, in_ready}, 2'b10);
    step();
    check("short_reload", in_ready, 1'b1);
    check("short_one_reset", n_reset - r0, 1);
    check("short_no_valid", n_ovalid - v0, 0);
    good_frame("realign", 1'b0, 0);

    // Missing in_last
    gen_frame(1'b0);
    send_frame(BINS - 1, -1);
    check("nolast_err_before", err_frame_cnt, exp_ef);
    send_beat(frame[BINS - 1], 1'b0);
    exp_ef++;
    check("nolast_err", err_frame_cnt, exp_ef);
    check("nolast_flush", fm_reset, 1'b1);
    step();
    check("nolast_reload", in_ready, 1'b1);

    // Watchdog with a finder that never answers
    stub_en = 1'b0;
    gen_frame(1'b0);
    send_frame(BINS, BINS - 1);
    check("wd_start", fm_start, 1'b1);
    repeat (TO + 1) step();
    check("wd_last_wait", {err_timeout_cnt, fm_reset, in_ready, out_valid}, {8'(exp_et), 3'b000});
    step();
    exp_et++;
    check("wd_abort", {err_timeout_cnt, fm_reset, in_ready}, {8'(exp_et), 2'b10});
    step();
    check("wd_reload", in_ready, 1'b1);
    stub_en = 1'b1;
    good_frame("after_wd", 1'b0, 0);

    // Asynchronous reset in the middle of a frame
    gen_frame(1'b0);
    send_frame(200, -1);
    #3 reset = 1'b0;
    #1;
    check("arst_immediate", {in_ready, out_valid, fm_reset}, 3'b001);
    check("arst_errs", {err_frame_cnt, err_timeout_cnt, out_frame_id}, '0);
    exp_fid = 0; exp_ef = 0; exp_et = 0;
    step();
    reset = 1'b1;
    check("arst_flush", fm_reset, 1'b1);
    step();
    check("arst_reload", {in_ready, fm_reset}, 2'b10);
    good_frame("after_arst", 1'b0, 0);

    // Random frames with random sink stalls
    for (int f = 0; f < 3; f++) good_frame("random", 1'b0, $urandom_range(0, 10));

    check("strobe_exclusive", n_viol, 0);
    check("final_errs", {err_frame_cnt, err_timeout_cnt}, {8'(exp_ef), 8'(exp_et)});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
